// File: rtl/jedro_1_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto one single-ported memory bus, one transaction in flight.
// Define JEDRO_1_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module jedro_1_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ifu_req_i,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_gnt_o,
  output logic                    ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  output logic                    ifu_err_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES)
                                                                    : {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1)
                                                                    : {CNT_WIDTH{1'b0}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_e;

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [BE_WIDTH-1:0]    mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   ifu_rvalid_q, ifu_rvalid_d, lsu_rvalid_q, lsu_rvalid_d;
  logic [DATA_WIDTH-1:0]  ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic                   ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;
  logic                   ifu_gnt_s, lsu_gnt_s, sel_lsu_s;

`ifdef JEDRO_1_ARB_RR_EN
  owner_e last_q, last_d;

  // Round-robin history: the requester granted most recently.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= OWN_LSU;
    end else begin
      last_q <= last_d;
    end
  end

  // Track each grant so a tie goes to the other requester next time.
  always_comb begin
    last_d = last_q;
    if (lsu_gnt_s) begin
      last_d = OWN_LSU;
    end else if (ifu_gnt_s) begin
      last_d = OWN_IFU;
    end else begin
      last_d = last_q;
    end
  end
`endif

  // Winner selection; a lone requester always wins.
  always_comb begin
    sel_lsu_s = 1'b0;
    if (lsu_req_i && ifu_req_i) begin
`ifdef JEDRO_1_ARB_RR_EN
      sel_lsu_s = (last_q == OWN_IFU);
`else
      sel_lsu_s = 1'b1;
`endif
    end else if (lsu_req_i) begin
      sel_lsu_s = 1'b1;
    end else begin
      sel_lsu_s = 1'b0;
    end
  end

  // Next-state, command latch and response routing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    ifu_err_d    = ifu_err_q;
    lsu_rdata_d  = lsu_rdata_q;
    lsu_err_d    = lsu_err_q;
    ifu_gnt_s    = 1'b0;
    lsu_gnt_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ifu_req_i || lsu_req_i) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
          if (sel_lsu_s) begin
            owner_d     = OWN_LSU;
            lsu_gnt_s   = 1'b1;
            mem_we_d    = lsu_we_i;
            mem_be_d    = lsu_be_i;
            mem_addr_d  = lsu_addr_i;
            mem_wdata_d = lsu_wdata_i;
          end else begin
            owner_d     = OWN_IFU;
            ifu_gnt_s   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = {BE_WIDTH{1'b1}};
            mem_addr_d  = ifu_addr_i;
            mem_wdata_d = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          cnt_d     = {CNT_WIDTH{1'b0}};
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        // A real response in the final timeout cycle takes precedence over the error.
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rvalid_d = 1'b1;
            lsu_rdata_d  = mem_rdata_i;
            lsu_err_d    = mem_err_i;
          end else begin
            ifu_rvalid_d = 1'b1;
            ifu_rdata_d  = mem_rdata_i;
            ifu_err_d    = mem_err_i;
          end
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rvalid_d = 1'b1;
            lsu_rdata_d  = {DATA_WIDTH{1'b0}};
            lsu_err_d    = 1'b1;
          end else begin
            ifu_rvalid_d = 1'b1;
            ifu_rdata_d  = {DATA_WIDTH{1'b0}};
            ifu_err_d    = 1'b1;
          end
        end else begin
          state_d = S_RESP;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, command and response registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IFU;
      cnt_q        <= {CNT_WIDTH{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= {BE_WIDTH{1'b0}};
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= {DATA_WIDTH{1'b0}};
      lsu_rdata_q  <= {DATA_WIDTH{1'b0}};
      ifu_err_q    <= 1'b0;
      lsu_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      ifu_err_q    <= ifu_err_d;
      lsu_err_q    <= lsu_err_d;
    end
  end

  // Grants are combinational but forced low while reset is held.
  assign ifu_gnt_o    = ifu_gnt_s & rstn_i;
  assign lsu_gnt_o    = lsu_gnt_s & rstn_i;
  assign ifu_rvalid_o = ifu_rvalid_q;
  assign ifu_rdata_o  = ifu_rdata_q;
  assign ifu_err_o    = ifu_err_q;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign lsu_rdata_o  = lsu_rdata_q;
  assign lsu_err_o    = lsu_err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Self-checking bench for jedro_1_mem_arbiter (default fixed-priority build, TIMEOUT_CYCLES=4).
module tb_jedro_1_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ifu_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0;
  logic [31:0] ifu_addr = 32'h0, lsu_addr = 32'h0, lsu_wdata = 32'h0, mem_rdata = 32'h0;
  logic [3:0]  lsu_be = 4'h0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic        ifu_gnt_o, ifu_rvalid_o, ifu_err_o, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] ifu_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [139:0] all_out;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct packed {logic lsu; logic [31:0] rdata; logic err;} exp_t;
  exp_t sb_q[$];
  exp_t me;

  typedef struct {
    logic lsu; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    int gnt_dly; int resp_dly; logic [31:0] mem_rdata; logic mem_err;
    logic exp_we; logic [3:0] exp_be; logic [31:0] exp_wdata;
    logic [31:0] exp_rdata; logic exp_err; int exp_lat;
  } vec_t;
  vec_t vecs[8];

  jedro_1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  assign all_out = {ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o, lsu_gnt_o, lsu_rvalid_o,
                    lsu_rdata_o, lsu_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (ifu_rvalid_o || lsu_rvalid_o) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL stray_rvalid: ifu=%0b lsu=%0b, expected no pulse", ifu_rvalid_o, lsu_rvalid_o);
      end else begin
        me = sb_q.pop_front();
        if ((lsu_rvalid_o !== me.lsu) || (ifu_rvalid_o !== !me.lsu) ||
            ((me.lsu ? lsu_rdata_o : ifu_rdata_o) !== me.rdata) ||
            ((me.lsu ? lsu_err_o : ifu_err_o) !== me.err)) begin
          n_fail++;
          $display("FAIL resp: got ifu_v=%0b lsu_v=%0b rdata=%h err=%0b, expected lsu=%0b rdata=%h err=%0b",
                   ifu_rvalid_o, lsu_rvalid_o, me.lsu ? lsu_rdata_o : ifu_rdata_o,
                   me.lsu ? lsu_err_o : ifu_err_o, me.lsu, me.rdata, me.err);
        end
      end
    end
  end

  task automatic apply_vec(input vec_t v, input int idx);
    int g;
    int got;
    exp_t e;
    logic [69:0] cmd_exp;
    @(posedge clk); #1;
    if (v.lsu) begin
      lsu_req = 1'b1; lsu_we = v.we; lsu_be = v.be; lsu_addr = v.addr; lsu_wdata = v.wdata;
    end else begin
      ifu_req = 1'b1; ifu_addr = v.addr;
      lsu_we = 1'b1; lsu_be = 4'h5; lsu_wdata = 32'h5555_5555;
    end
    @(negedge clk);
    check($sformatf("v%0d_gnt", idx), {ifu_gnt_o, lsu_gnt_o}, {~v.lsu, v.lsu});
    e.lsu = v.lsu; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    ifu_req = 1'b0; lsu_req = 1'b0;
    ifu_addr = ~v.addr; lsu_addr = ~v.addr; lsu_wdata = ~v.wdata; lsu_we = ~v.we; lsu_be = ~v.be;
    cmd_exp = {1'b1, v.exp_we, v.exp_be, v.addr, v.exp_wdata};
    for (int k = 0; k < v.gnt_dly; k++) begin
      @(negedge clk);
      check($sformatf("v%0d_cmd_hold", idx), {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, cmd_exp);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_cmd", idx), {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, cmd_exp);
    g = cyc;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (v.resp_dly >= 0) begin
      for (int k = 0; k < v.resp_dly; k++) begin
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1; mem_rdata = v.mem_rdata; mem_err = v.mem_err;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    end
    got = -1;
    for (int k = 0; k < 30 && got < 0; k++) begin
      @(negedge clk);
      if (ifu_rvalid_o || lsu_rvalid_o) got = cyc - g;
    end
    check($sformatf("v%0d_latency", idx), 160'(got), 160'(v.exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_lsu;
    int n_ifu;
    exp_t e;
    //        lsu   we    be     addr          wdata         gd rd  mem_rdata     merr  we    be     wdata         rdata         err  lat
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'h0000ABCD, 0, 0, 32'h0,        1'b0, 1'b1, 4'h3, 32'h0000ABCD, 32'h0,        1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0,        1, 0, 32'h12345678, 1'b1, 1'b0, 4'hF, 32'h0,        32'h12345678, 1'b1, 2};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,       10, 1, 32'hCAFEF00D, 1'b0, 1'b0, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0, 3};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_3008, 32'h0,        0, 3, 32'h0BADC0DE, 1'b0, 1'b0, 4'hF, 32'h0,        32'h0BADC0DE, 1'b0, 5};
    vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h0000_300C, 32'h0,        0,-1, 32'h0,        1'b0, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 5};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_0108, 32'h0,        2,-1, 32'h0,        1'b0, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 5};
    vecs[7] = '{1'b1, 1'b1, 4'h8, 32'hFFFF_FFFC, 32'hA5A5A5A5, 0, 2, 32'h0,        1'b0, 1'b1, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 4};

    // Reset state, with both requests asserted so grant gating is exercised.
    ifu_req = 1'b1; lsu_req = 1'b1;
    #2;
    check("reset_outputs", all_out, 140'h0);
    ifu_req = 1'b0; lsu_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i], i);
      if (i == 5) begin
        // Stray response while idle after a timeout must be dropped.
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("stray_idle", {ifu_rvalid_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o}, {2'b00, 32'h0, 1'b1});
      end
    end

    // LSU write contends with IFU read: LSU first, IFU granted on the LSU response cycle.
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011; lsu_addr = 32'h2004; lsu_wdata = 32'h0000ABCD;
    ifu_req = 1'b1; ifu_addr = 32'h200;
    @(negedge clk);
    check("cont_gnt", {ifu_gnt_o, lsu_gnt_o}, 2'b01);
    e = '{1'b1, 32'h0, 1'b0};          sb_q.push_back(e);
    e = '{1'b0, 32'h1111_2222, 1'b0};  sb_q.push_back(e);
    @(posedge clk); #1;
    lsu_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    check("cont_lsu_cmd", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
          {1'b1, 1'b1, 4'b0011, 32'h2004, 32'h0000ABCD});
    check("cont_ifu_wait1", ifu_gnt_o, 1'b0);
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    check("cont_ifu_wait2", {ifu_gnt_o, ifu_rvalid_o}, 2'b00);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("cont_handover", {lsu_rvalid_o, ifu_gnt_o, mem_req_o}, 3'b110);
    @(posedge clk); #1;
    ifu_req = 1'b0; ifu_addr = 32'hBAD0_0000; mem_gnt = 1'b1;
    @(negedge clk);
    check("cont_ifu_cmd", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
          {1'b1, 1'b0, 4'hF, 32'h200, 32'h0});
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("cont_ifu_rvalid", ifu_rvalid_o, 1'b1);

    // Both requesting continuously for 6 grants: fixed priority gives all to the LSU.
    @(posedge clk); #1;
    ifu_req = 1'b1; ifu_addr = 32'h400;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h500; lsu_wdata = 32'h0;
    n_lsu = 0; n_ifu = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_lsu += int'(lsu_gnt_o);
      n_ifu += int'(ifu_gnt_o);
      e = '{1'b1, 32'h1000 + 32'(i), 1'b0};
      sb_q.push_back(e);
      @(posedge clk); #1;
      mem_gnt = 1'b1;
      if (i == 5) begin
        ifu_req = 1'b0; lsu_req = 1'b0;
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(i);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
    end
    check("prio_lsu_grants", 160'(n_lsu), 160'd6);
    check("prio_ifu_grants", 160'(n_ifu), 160'd0);

    // Reset asserted mid-RESP clears outputs asynchronously; stale response afterwards is dropped.
    @(posedge clk); #1;
    ifu_req = 1'b1; ifu_addr = 32'h600;
    @(negedge clk);
    check("rst_pre_gnt", ifu_gnt_o, 1'b1);
    @(posedge clk); #1;
    ifu_req = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; lsu_req = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async_outputs", all_out, 140'h0);
    @(negedge clk);
    lsu_req = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("rst_stale_drop", {ifu_rvalid_o, lsu_rvalid_o, ifu_rdata_o, mem_req_o}, 35'h0);
    apply_vec(vecs[0], 99);

    repeat (2) @(negedge clk);
    check("sb_empty", 160'(sb_q.size()), 160'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
